// File: rtl/mem_responder_if.sv
// Bus between the control-unit side (master) and the memory responder (slave).
// Carries the MAR/data access strobes, the loader write port and the
// responder's completion/error outputs. Widths must match the responder's.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mar_addr;
  logic [DATA_W-1:0] data_in;
  logic              rmem;
  logic              wmem;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] data_out;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output mar_addr, data_in, rmem, wmem, ld_en, ld_addr, ld_data,
    input  data_out, ready, busy, err
  );

  modport slave (
    input  mar_addr, data_in, rmem, wmem, ld_en, ld_addr, ld_data,
    output data_out, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the control unit's rmem/wmem strobes.
// Accepts a request on a strobe rising edge, waits WAIT_CYCLES, performs the
// access on latched address/data, then pulses ready for one cycle.
// A loader port preloads words while the responder is idle.
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  S_IDLE | waiting for a strobe edge; loader writes allowed
//  S_WAIT | wait-state countdown on cnt, request already latched
//  S_ACC  | storage read/write using the latched request
//  S_DONE | ready pulse cycle, busy still high
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DEPTH_I = DEPTH;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH_I[ADDR_W:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rmem_q;
  logic              wmem_q;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;

  // Storage is deliberately not reset so a preloaded program survives reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic             rd_rise;
  logic             wr_rise;
  logic             req_edge;
  logic             both_rise;
  logic             lat_valid;
  logic             ld_valid;
  logic             ld_ok;
  logic             ld_bad;
  logic             acc_wr;
  logic [IDX_W-1:0] lat_idx;
  logic [IDX_W-1:0] ld_idx;

  // Request edge detection, address range checks and loader arbitration.
  always_comb begin
    rd_rise   = bus.rmem & ~rmem_q;
    wr_rise   = bus.wmem & ~wmem_q;
    req_edge  = rd_rise | wr_rise;
    both_rise = rd_rise & wr_rise;
    lat_valid = ({1'b0, lat_addr} < DEPTH_L);
    ld_valid  = ({1'b0, bus.ld_addr} < DEPTH_L);
    lat_idx   = lat_addr[IDX_W-1:0];
    ld_idx    = bus.ld_addr[IDX_W-1:0];
    ld_ok     = bus.ld_en && (state == S_IDLE) && !req_edge && ld_valid;
    ld_bad    = bus.ld_en && !ld_ok;
    acc_wr    = (state == S_ACC) && lat_wr && lat_valid;
  end

  // Sequencer with registered outputs; strobe history is tracked in every
  // state so a strobe held across an access never looks like a new request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rmem_q       <= 1'b0;
      wmem_q       <= 1'b0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_wr       <= 1'b0;
      bus.data_out <= '0;
      bus.ready    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      rmem_q    <= bus.rmem;
      wmem_q    <= bus.wmem;
      bus.ready <= 1'b0;
      bus.err   <= ld_bad;
      case (state)
        S_IDLE: begin
          if (both_rise) begin
            bus.err <= 1'b1;
          end else if (req_edge) begin
            lat_addr <= bus.mar_addr;
            lat_data <= bus.data_in;
            lat_wr   <= wr_rise;
            cnt      <= 4'(WAIT_CYCLES);
            bus.busy <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_ACC;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACC: begin
          if (!lat_wr) begin
            bus.data_out <= lat_valid ? mem[lat_idx] : '0;
          end
          if (!lat_valid) begin
            bus.err <= 1'b1;
          end
          bus.ready <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Storage writes: loader only in IDLE, access write only in ACC, so the two never collide.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem[ld_idx] <= bus.ld_data;
    end else if (acc_wr) begin
      mem[lat_idx] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (DEPTH=200/WAIT=2 and DEPTH=256/WAIT=0)
// share one stimulus driver selected by sel; expectations come from a word
// model per instance and a scoreboard queue of per-access expectations.
module tb_mem_responder;

  localparam int W0 = 2;
  localparam int D0 = 200;
  localparam int W1 = 0;
  localparam int D1 = 256;
  localparam int LAT0 = W0 + 2;
  localparam int LAT1 = W1 + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        rmem_d = 1'b0;
  logic        wmem_d = 1'b0;
  logic        ld_en_d = 1'b0;
  logic [7:0]  mar_d = '0;
  logic [15:0] din_d = '0;
  logic [7:0]  ld_addr_d = '0;
  logic [15:0] ld_data_d = '0;

  logic [15:0] o_data;
  logic        o_ready;
  logic        o_busy;
  logic        o_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [15:0] model0 [256];
  logic [15:0] model1 [256];
  logic [15:0] exp_dout0 = '0;
  logic [15:0] exp_dout1 = '0;

  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) if0 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) if1 ();

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(D0), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(if0.slave)
  );
  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(D1), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .reset(rst_n), .bus(if1.slave)
  );

  assign if0.mar_addr = mar_d;
  assign if0.data_in  = din_d;
  assign if0.rmem     = rmem_d & ~sel;
  assign if0.wmem     = wmem_d & ~sel;
  assign if0.ld_en    = ld_en_d & ~sel;
  assign if0.ld_addr  = ld_addr_d;
  assign if0.ld_data  = ld_data_d;
  assign if1.mar_addr = mar_d;
  assign if1.data_in  = din_d;
  assign if1.rmem     = rmem_d & sel;
  assign if1.wmem     = wmem_d & sel;
  assign if1.ld_en    = ld_en_d & sel;
  assign if1.ld_addr  = ld_addr_d;
  assign if1.ld_data  = ld_data_d;

  assign o_data  = sel ? if1.data_out : if0.data_out;
  assign o_ready = sel ? if1.ready    : if0.ready;
  assign o_busy  = sel ? if1.busy     : if0.busy;
  assign o_err   = sel ? if1.err      : if0.err;

  always #5 clk = ~clk;

  // One loader word; err_seen is err in the cycle after the sampling edge.
  task automatic load(input logic [7:0] a, input logic [15:0] d, output logic err_seen);
    @(posedge clk); #1;
    ld_en_d = 1'b1; ld_addr_d = a; ld_data_d = d;
    @(posedge clk); #1;
    ld_en_d = 1'b0;
    @(negedge clk);
    err_seen = o_err;
  endtask

  // One strobe-driven access; returns observations only, callers compare.
  task automatic access(input bit wr, input logic [7:0] addr, input logic [15:0] din, input int hold,
                        output int lat, output logic [15:0] dout, output logic err_rdy,
                        output int err_other, output int ready_extra, output bit busy_ok);
    lat = -1; dout = 'x; err_rdy = 1'bx; err_other = 0; ready_extra = 0; busy_ok = 1'b1;
    @(posedge clk); #1;
    mar_d = addr; din_d = din;
    if (wr) wmem_d = 1'b1; else rmem_d = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_ready === 1'b1) begin
        lat = n; dout = o_data; err_rdy = o_err;
        break;
      end
      if (o_err === 1'b1) err_other++;
    end
    if (lat >= 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (o_ready === 1'b1) ready_extra++;
        if (o_err === 1'b1) err_other++;
      end
    end
    @(posedge clk); #1;
    rmem_d = 1'b0; wmem_d = 1'b0;
    @(negedge clk);
    if (o_busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if0.data_out !== 16'h0) begin failures++; $display("FAIL reset_data_out got=%h want=0000", if0.data_out); end
    checks++; if (if0.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", if0.ready); end
    checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", if0.busy); end
    checks++; if (if0.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", if0.err); end
    checks++; if (if1.busy !== 1'b0 || if1.ready !== 1'b0) begin failures++; $display("FAIL reset_dut1 got busy=%b ready=%b want 0 0", if1.busy, if1.ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_read();
    logic le, er; int lat, eo, rx; logic [15:0] d; bit bo; exp_t e;
    sel = 1'b0;
    load(8'd5, 16'h1234, le); model0[5] = 16'h1234;
    checks++; if (le !== 1'b0) begin failures++; $display("FAIL t1_load_err got=%b want=0", le); end
    exp_dout0 = model0[5];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    access(1'b0, 8'd5, 16'h0, 0, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data) begin failures++; $display("FAIL t1_data got=%h want=%h", d, e.data); end
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL t1_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (er !== e.err || eo !== 0) begin failures++; $display("FAIL t1_err got=%b/%0d want=%b/0", er, eo, e.err); end
    checks++; if (bo !== 1'b1) begin failures++; $display("FAIL t1_busy_window got=%b want=1", bo); end
  endtask

  task automatic test_write_read_hold();
    logic er; int lat, eo, rx; logic [15:0] d; bit bo; exp_t e;
    sel = 1'b0;
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    access(1'b1, 8'd9, 16'hBEEF, 0, lat, d, er, eo, rx, bo);
    if (9 < D0) model0[9] = 16'hBEEF;
    e = sb.pop_front();
    checks++; if (d !== e.data) begin failures++; $display("FAIL t2_write_keeps_data_out got=%h want=%h", d, e.data); end
    checks++; if (lat !== e.lat || er !== e.err || bo !== 1'b1) begin failures++; $display("FAIL t2_write_done got lat=%0d err=%b busy=%b want lat=%0d err=%b busy=1", lat, er, bo, e.lat, e.err); end
    exp_dout0 = model0[9];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    access(1'b0, 8'd9, 16'h0, 5, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data) begin failures++; $display("FAIL t2_read_data got=%h want=%h", d, e.data); end
    checks++; if (rx !== 0) begin failures++; $display("FAIL t2_single_ready got_extra=%0d want=0", rx); end
    checks++; if (er !== 1'b0 || eo !== 0) begin failures++; $display("FAIL t2_err got=%b/%0d want=0/0", er, eo); end
  endtask

  task automatic test_errors();
    logic er, le; int lat, eo, rx; logic [15:0] d; bit bo; exp_t e;
    sel = 1'b0;
    @(posedge clk); #1;
    mar_d = 8'd5; din_d = 16'hFFFF; rmem_d = 1'b1; wmem_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL t3_both_edges got err=%b busy=%b want err=1 busy=0", o_err, o_busy); end
    @(negedge clk);
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL t3_both_edges_after got err=%b busy=%b want 0 0", o_err, o_busy); end
    @(posedge clk); #1;
    rmem_d = 1'b0; wmem_d = 1'b0;
    sb.push_back('{16'h0, 1'b1, LAT0});
    access(1'b0, 8'd255, 16'h0, 0, lat, d, er, eo, rx, bo);
    exp_dout0 = 16'h0;
    e = sb.pop_front();
    checks++; if (d !== e.data || er !== e.err || lat !== e.lat) begin failures++; $display("FAIL t3_bad_read got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d", d, er, lat, e.data, e.err, e.lat); end
    exp_dout0 = model0[5];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    access(1'b0, 8'd5, 16'h0, 0, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data || er !== e.err) begin failures++; $display("FAIL t3_storage_unchanged got data=%h err=%b want data=%h err=%b", d, er, e.data, e.err); end
    sb.push_back('{exp_dout0, 1'b1, LAT0});
    access(1'b1, 8'd210, 16'h4321, 0, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data || er !== e.err || lat !== e.lat) begin failures++; $display("FAIL t3_bad_write got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d", d, er, lat, e.data, e.err, e.lat); end
    load(8'd220, 16'h7777, le);
    checks++; if (le !== 1'b1) begin failures++; $display("FAIL t3_bad_load_err got=%b want=1", le); end
  endtask

  task automatic test_load_busy();
    logic er, ld_err; int lat, eo, rx; logic [15:0] d; bit bo; exp_t e;
    sel = 1'b0;
    ld_err = 1'b0;
    exp_dout0 = model0[9];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    fork
      access(1'b0, 8'd9, 16'h0, 0, lat, d, er, eo, rx, bo);
      begin
        @(posedge clk); @(posedge clk); #1;
        ld_en_d = 1'b1; ld_addr_d = 8'd9; ld_data_d = 16'h5555;
        @(posedge clk); #1;
        ld_en_d = 1'b0;
        @(negedge clk);
        ld_err = o_err;
      end
    join
    e = sb.pop_front();
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL t4_busy_load_err got=%b want=1", ld_err); end
    checks++; if (d !== e.data || er !== e.err || lat !== e.lat) begin failures++; $display("FAIL t4_inflight_read got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d", d, er, lat, e.data, e.err, e.lat); end
    exp_dout0 = model0[5];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    fork
      access(1'b0, 8'd5, 16'h0, 0, lat, d, er, eo, rx, bo);
      begin
        @(posedge clk); #1;
        ld_en_d = 1'b1; ld_addr_d = 8'd5; ld_data_d = 16'h7777;
        @(posedge clk); #1;
        ld_en_d = 1'b0;
        @(negedge clk);
        ld_err = o_err;
      end
    join
    e = sb.pop_front();
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL t4_edge_load_err got=%b want=1", ld_err); end
    checks++; if (d !== e.data || lat !== e.lat) begin failures++; $display("FAIL t4_edge_read got data=%h lat=%0d want data=%h lat=%0d", d, lat, e.data, e.lat); end
    exp_dout0 = model0[9];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    access(1'b0, 8'd9, 16'h0, 0, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data) begin failures++; $display("FAIL t4_word_dropped got=%h want=%h", d, e.data); end
  endtask

  task automatic test_reset_mid();
    logic le, er; int lat, eo, rx; logic [15:0] d; bit bo; exp_t e;
    sel = 1'b0;
    load(8'd3, 16'h0333, le); model0[3] = 16'h0333;
    @(posedge clk); #1;
    mar_d = 8'd3; din_d = 16'hAAAA; wmem_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL t5_busy_before_reset got=%b want=1", o_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b0 || o_err !== 1'b0 || o_data !== 16'h0) begin failures++; $display("FAIL t5_async_reset got busy=%b ready=%b err=%b data=%h want 0 0 0 0000", o_busy, o_ready, o_err, o_data); end
    wmem_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_dout0 = model0[3];
    sb.push_back('{exp_dout0, 1'b0, LAT0});
    access(1'b0, 8'd3, 16'h0, 0, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data || lat !== e.lat) begin failures++; $display("FAIL t5_aborted_write got data=%h lat=%0d want data=%h lat=%0d", d, lat, e.data, e.lat); end
  endtask

  task automatic test_back_to_back();
    logic le, er; int lat, eo, rx; logic [15:0] d; bit bo; exp_t e;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(8'(10 + i), 16'hA000 + 16'(i * 16'h0111), le);
      model1[10 + i] = 16'hA000 + 16'(i * 16'h0111);
    end
    for (int i = 0; i < 4; i++) begin
      exp_dout1 = model1[10 + i];
      sb.push_back('{exp_dout1, 1'b0, LAT1});
      access(1'b0, 8'(10 + i), 16'h0, 0, lat, d, er, eo, rx, bo);
      e = sb.pop_front();
      checks++; if (d !== e.data || lat !== e.lat || er !== e.err || bo !== 1'b1) begin failures++; $display("FAIL t6_b2b_read%0d got data=%h lat=%0d err=%b busy=%b want data=%h lat=%0d err=%b busy=1", i, d, lat, er, bo, e.data, e.lat, e.err); end
    end
    sb.push_back('{exp_dout1, 1'b0, LAT1});
    access(1'b1, 8'd40, 16'hC0DE, 0, lat, d, er, eo, rx, bo);
    model1[40] = 16'hC0DE;
    e = sb.pop_front();
    checks++; if (d !== e.data || lat !== e.lat || er !== e.err) begin failures++; $display("FAIL t6_b2b_write got data=%h lat=%0d err=%b want data=%h lat=%0d err=%b", d, lat, er, e.data, e.lat, e.err); end
    exp_dout1 = model1[40];
    sb.push_back('{exp_dout1, 1'b0, LAT1});
    access(1'b0, 8'd40, 16'h0, 0, lat, d, er, eo, rx, bo);
    e = sb.pop_front();
    checks++; if (d !== e.data || lat !== e.lat) begin failures++; $display("FAIL t6_b2b_readback got data=%h lat=%0d want data=%h lat=%0d", d, lat, e.data, e.lat); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_write_read_hold();
    test_errors();
    test_load_busy();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
